gost_cbc_dec: RTL and testbench
===============================

# gost_cbc_dec

Magma (GOST R 34.12-2015, 64-bit block, 256-bit key) CBC-mode decryptor. It is the receive-side counterpart of `gost_cbc`: it accepts a 128-bit word holding two ciphertext blocks and returns the two recovered plaintext blocks. The start/done handshake is identical to the encryptor's, so a testbench can chain `gost_cbc` → `gost_cbc_dec` directly. Rounds are iterated, one Feistel round per clock.

## Interface
- `KEY`, default `256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff`, cipher key; K1 = `KEY[255:224]` … K8 = `KEY[31:0]`.
- `IV`, default `64'h0`, initial chaining value restored by reset.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_in` in 128: ciphertext; `[127:64]` = block C0 (first), `[63:0]` = block C1.
- `start_trigger` in 1: level; sampled in IDLE.
- `data_out` out 128: plaintext; `[127:64]` = P0, `[63:0]` = P1; registered.
- `done_block` out 1: one-cycle pulse when `data_out` is valid.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE with `start_trigger`=1 at a clock edge:
  - capture `data_in` into `cin`;
  - load the cipher state with C0;
  - clear round counter `rnd` (5 bit) and block index `blk`;
  - go to ROUND.
- ROUND: one round per cycle. State is (a1, a0), with a1 = `[63:32]`.
  - g = rotl11(S(a0 + k mod 2^32)).
  - Rounds 0–30: (a1, a0) ← (a0, a1 ^ g).
  - Round 31: result = {a1 ^ g, a0}, no swap.
- Decryption key order: K1..K8 once, then K8..K1 three times.
  - Round r < 8: K(r+1). Round r ≥ 8: K(8 − (r mod 8)).
- S: eight 4-bit S-boxes, nibble i = bits [4i+3:4i] through Pi_i. Each box lists hex outputs for inputs 0..F:
  - Pi0 C462A5B9E8D703F1
  - Pi1 6823 9A5C 1E47BD0F
  - Pi2 B358 2FAD E174 C960
  - Pi3 C821 D4F6 70A5 3E9B
  - Pi4 7F5A 816D 093E B42C
  - Pi5 5DF6 92CA B781 43E0
  - Pi6 8E25 691C F4B0 DA37
  - Pi7 17ED 0583 4FA6 9CB2
- End of block 0 (`blk`=0, `rnd`=31):
  - P0 = result ^ `chain`;
  - load the cipher state with C1; `blk` ← 1; `rnd` ← 0.
- End of block 1:
  - P1 = result ^ C0;
  - `data_out` ← {P0, P1}; `chain` ← C1 (CBC continues across operations);
  - go to DONE.
- DONE: `done_block`=1 for exactly this cycle; return to IDLE.
- `data_in` changes after capture are ignored.
- `start_trigger` held high gives back-to-back operations, one every 66 cycles. Each uses the updated chain.
- Reset, asynchronous, also mid-operation:
  - state=IDLE, `rnd`=0, `blk`=0, `data_out`=0, `done_block`=0, `chain`=`IV`;
  - the in-flight operation is discarded.

## Timing
- Edge E0: start sampled in IDLE.
- Edges E1..E32: block-0 rounds 0..31.
- Edges E33..E64: block-1 rounds.
- E64 writes `data_out` and enters DONE.
- `done_block` is high between E64 and E65, and `data_out` is stable from E64.
- Latency, start sample to done: 64 cycles. Issue interval: 66 cycles.
- `start_trigger` is ignored outside IDLE. There is no queuing.
- `data_out` holds its value until the next completion or reset.

## Test plan
- Single op, default KEY/IV. Stimulus: `data_in`=`128'h4ee901e5c2d8ca3d4ee901e5c2d8ca3d`, start pulsed for one cycle. Required: `done_block` 64 cycles after the sample; `data_out`=`128'hfedcba9876543210b035bb7db48cf82d`.
- Chain continuity. Stimulus: the same input again. Required: `data_out`=`128'hb035bb7db48cf82db035bb7db48cf82d`, because the chain is now C1.
- Reset restores IV. Stimulus: assert `reset_n` low, release, rerun the first scenario. Required: `fedcba9876543210b035bb7db48cf82d` again; all outputs 0 during reset.
- Reset mid-operation. Stimulus: pull `reset_n` low at round 40. Required: no `done_block`, `data_out`=0, and the next op matches the first scenario.
- Held start. Stimulus: `start_trigger` tied to 1. Required: `done_block` pulses every 66 cycles; first result as in the first scenario, subsequent results as in the second.
- Loopback. Stimulus: drive `gost_cbc` with `data_in`=`128'h1122334455667700ffeeddccbbaa9988`, same KEY/IV, and feed its `data_out` into this block. Required: the recovered output equals `128'h1122334455667700ffeeddccbbaa9988`.

Source files
------------

// File: rtl/gost_cbc_dec.sv
// Magma (64-bit block, 256-bit key) CBC decryptor for two blocks per operation.
// Runs one Feistel round per clock: 64 cycles from the start sample to done.
module gost_cbc_dec #(
  parameter logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
  parameter logic [63:0]  IV  = 64'h0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] data_in,
  input  logic         start_trigger,
  output logic [127:0] data_out,
  output logic         done_block,
  output logic [1:0]   state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Handshake: start_trigger is a level sampled only in IDLE; done_block is a
  // one-cycle pulse and data_out is valid from that cycle until the next completion.

  logic [1:0]   state;
  logic [4:0]   rnd;
  logic         blk;
  logic [127:0] cin;
  logic [63:0]  a;
  logic [63:0]  p0;
  logic [63:0]  chain;

  logic [2:0]   kidx;
  logic [31:0]  rkey;
  logic [31:0]  sum;
  logic [31:0]  sub;
  logic [31:0]  g;
  logic [63:0]  res;

  function automatic logic [63:0] pi_tab(input logic [2:0] i);
    case (i)
      3'd0:    pi_tab = 64'hC462A5B9E8D703F1;
      3'd1:    pi_tab = 64'h68239A5C1E47BD0F;
      3'd2:    pi_tab = 64'hB3582FADE174C960;
      3'd3:    pi_tab = 64'hC821D4F670A53E9B;
      3'd4:    pi_tab = 64'h7F5A816D093EB42C;
      3'd5:    pi_tab = 64'h5DF692CAB78143E0;
      3'd6:    pi_tab = 64'h8E25691CF4B0DA37;
      default: pi_tab = 64'h17ED05834FA69CB2;
    endcase
  endfunction

  // Table entries are listed for inputs 0..F starting at the most significant nibble.
  function automatic logic [31:0] s_layer(input logic [31:0] x);
    logic [63:0] t;
    logic [3:0]  v;
    s_layer = '0;
    for (int i = 0; i < 8; i++) begin
      t = pi_tab(3'(i));
      v = x[4*i +: 4];
      s_layer[4*i +: 4] = t[4*(15 - int'(v)) +: 4];
    end
  endfunction

  // Decryption schedule: K1..K8 for rounds 0..7, then K8..K1 repeated.
  assign kidx = (rnd < 5'd8) ? rnd[2:0] : ~rnd[2:0];
  assign rkey = KEY[32*(7 - int'(kidx)) +: 32];
  assign sum  = a[31:0] + rkey;
  assign sub  = s_layer(sum);
  assign g    = {sub[20:0], sub[31:21]};
  assign res  = {a[63:32] ^ g, a[31:0]};

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rnd        <= '0;
      blk        <= 1'b0;
      cin        <= '0;
      a          <= '0;
      p0         <= '0;
      chain      <= IV;
      data_out   <= '0;
      done_block <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_block <= 1'b0;
          if (start_trigger) begin
            cin   <= data_in;
            a     <= data_in[127:64];
            rnd   <= '0;
            blk   <= 1'b0;
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (rnd != 5'd31) begin
            a   <= {a[31:0], a[63:32] ^ g};
            rnd <= rnd + 5'd1;
          end else if (!blk) begin
            p0  <= res ^ chain;
            a   <= cin[63:0];
            blk <= 1'b1;
            rnd <= '0;
          end else begin
            data_out   <= {p0, res ^ cin[127:64]};
            chain      <= cin[63:0];
            done_block <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          done_block <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          done_block <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gost_cbc_dec.sv
// Directed bench for gost_cbc_dec: known-answer vectors, chaining, resets,
// held start and an encrypt-then-decrypt loopback through a reference encryptor.
module tb_gost_cbc_dec;

  localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] VEC_IN  = 128'h4ee901e5c2d8ca3d4ee901e5c2d8ca3d;
  localparam logic [127:0] EXP_R1  = 128'hfedcba9876543210b035bb7db48cf82d;
  localparam logic [127:0] EXP_R2  = 128'hb035bb7db48cf82db035bb7db48cf82d;
  localparam logic [127:0] LOOP_PT = 128'h1122334455667700ffeeddccbbaa9988;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] data_in;
  logic         start_trigger;
  logic [127:0] data_out;
  logic         done_block;
  logic [1:0]   state_dbg;
  int           cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gost_cbc_dec dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .start_trigger (start_trigger),
    .data_out      (data_out),
    .done_block    (done_block),
    .state_dbg     (state_dbg)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encryptor (K1..K8 three times, then K8..K1).
  function automatic logic [63:0] ref_pi(input int i);
    case (i)
      0:       ref_pi = 64'hC462A5B9E8D703F1;
      1:       ref_pi = 64'h68239A5C1E47BD0F;
      2:       ref_pi = 64'hB3582FADE174C960;
      3:       ref_pi = 64'hC821D4F670A53E9B;
      4:       ref_pi = 64'h7F5A816D093EB42C;
      5:       ref_pi = 64'h5DF692CAB78143E0;
      6:       ref_pi = 64'h8E25691CF4B0DA37;
      default: ref_pi = 64'h17ED05834FA69CB2;
    endcase
  endfunction

  function automatic logic [63:0] magma_enc(input logic [63:0] pt);
    logic [63:0] a;
    logic [63:0] t;
    logic [31:0] k, x, y, g;
    int idx;
    a = pt;
    for (int r = 0; r < 32; r++) begin
      idx = (r < 24) ? (r % 8) : (7 - (r % 8));
      k = KEY[32*(7 - idx) +: 32];
      x = a[31:0] + k;
      for (int i = 0; i < 8; i++) begin
        t = ref_pi(i);
        y[4*i +: 4] = t[4*(15 - int'(x[4*i +: 4])) +: 4];
      end
      g = {y[20:0], y[31:21]};
      if (r < 31) a = {a[31:0], a[63:32] ^ g};
      else        a = {a[63:32] ^ g, a[31:0]};
    end
    return a;
  endfunction

  task automatic wait_done(input string tag, output logic [127:0] dout, output int lat);
    logic got;
    got  = 1'b0;
    lat  = 0;
    dout = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_block) begin
        got  = 1'b1;
        dout = data_out;
      end
    end
    check({tag, "_done_seen"}, 128'(got), 128'd1);
  endtask

  task automatic run_op(input string tag, input logic [127:0] din, output logic [127:0] dout, output int lat);
    @(negedge clk);
    data_in       = din;
    start_trigger = 1'b1;
    @(posedge clk);
    #1;
    start_trigger = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    wait_done(tag, dout, lat);
  endtask

  task automatic check_pulse(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse_width"}, 128'(done_block), 128'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check({tag, "_rst_data_out"}, data_out, 128'd0);
    check({tag, "_rst_done"}, 128'(done_block), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] held_res [3];
    int           held_cyc [3];
    int           lat;
    logic         seen;
    logic [63:0]  c0, c1;

    reset_n       = 1'b0;
    start_trigger = 1'b0;
    data_in       = '0;
    #12;
    check("por_data_out", data_out, 128'd0);
    check("por_done", 128'(done_block), 128'd0);
    check("por_state", 128'(state_dbg), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Known answer with IV chain, then chaining into the next operation.
    run_op("s1", VEC_IN, d, lat);
    check("s1_latency", 128'(lat), 128'd64);
    check("s1_data", d, EXP_R1);
    check_pulse("s1");

    run_op("s2", VEC_IN, d, lat);
    check("s2_latency", 128'(lat), 128'd64);
    check("s2_data", d, EXP_R2);
    check_pulse("s2");
    repeat (5) @(posedge clk);
    #1;
    check("s2_hold", data_out, EXP_R2);

    do_reset("s3");
    run_op("s3", VEC_IN, d, lat);
    check("s3_data", d, EXP_R1);

    // Reset while block-1 round 8 (overall round 40) is in flight.
    @(negedge clk);
    data_in       = VEC_IN;
    start_trigger = 1'b1;
    @(posedge clk);
    #1;
    start_trigger = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("s4_rst_data_out", data_out, 128'd0);
    check("s4_rst_done", 128'(done_block), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done_block) seen = 1'b1;
    end
    check("s4_no_done", 128'(seen), 128'd0);
    check("s4_data_out_zero", data_out, 128'd0);
    run_op("s4_next", VEC_IN, d, lat);
    check("s4_next_data", d, EXP_R1);

    // Held start: back-to-back operations every 66 cycles.
    do_reset("s5");
    @(negedge clk);
    data_in       = VEC_IN;
    start_trigger = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done("s5_op", held_res[k], lat);
      held_cyc[k] = cyc;
    end
    start_trigger = 1'b0;
    check("s5_res0", held_res[0], EXP_R1);
    check("s5_res1", held_res[1], EXP_R2);
    check("s5_res2", held_res[2], EXP_R2);
    check("s5_interval0", 128'(held_cyc[1] - held_cyc[0]), 128'd66);
    check("s5_interval1", 128'(held_cyc[2] - held_cyc[1]), 128'd66);
    repeat (4) @(posedge clk);

    // Loopback: reference CBC encryption from IV=0, decrypted by the DUT.
    do_reset("s6");
    c0 = magma_enc(LOOP_PT[127:64] ^ 64'h0);
    c1 = magma_enc(LOOP_PT[63:0] ^ c0);
    run_op("s6", {c0, c1}, d, lat);
    check("s6_loopback", d, LOOP_PT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
